tmpl_scan_ctrl: RTL and testbench
=================================

// Module: tmpl_scan_ctrl
// PURPOSE
//  Sequencer for the 16x16 template lookup ROM (IMG_SEARCH-style, registered, fixed latency).
//  On iSTART it sweeps every template cell in raster order and drives scaled coordinates oX/oY into the ROM.
//  It aligns the returned iVAL samples and accumulates template statistics (dark-cell count, pixel sum).
//  Results feed the template-match stage of the camera pipeline.
// PARAMETERS
//  HALVING  4        log2 of pixels per template cell; oX = cx<<HALVING, oY = cy<<HALVING
//  GRID     16       cells per side; total cells = GRID*GRID = 256
//  LAT      3        ROM latency in cycles, from oX/oY driven to matching iVAL
//  THRESH   10'd128  cell is dark when iVAL < THRESH
// PORTS
//  iCLK        in   1   clock
//  iRST        in   1   asynchronous reset, active-high
//  iSTART      in   1   start scan; sampled only in IDLE
//  oBUSY       out  1   high from start accept until the oDONE cycle (inclusive)
//  oDONE       out  1   one-cycle pulse; results valid from this cycle on
//  oX          out  13  ROM X coordinate
//  oY          out  13  ROM Y coordinate
//  iVAL        in   10  ROM data, LAT cycles after oX/oY
//  oDARK_CNT   out  9   number of dark cells, 0..256
//  oSUM        out  18  sum of iVAL over all cells, max 256*1023
//  oMIN_X/oMAX_X/oMIN_Y/oMAX_Y  out 4 each  dark-cell bounding box (TMPL_SCAN_BBOX_EN only)
//  oBBOX_VALID out  1   at least one dark cell found (TMPL_SCAN_BBOX_EN only)
// BEHAVIOUR
//  - Reset, async: state IDLE; cx = cy = 0; valid pipe cleared; all outputs 0.
//    Reset mid-scan aborts the scan; no oDONE is produced.
//  - FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  - IDLE: when iSTART = 1 at edge E0:
//    - clear internal accumulators and cx, cy;
//    - oBUSY = 1 after E0;
//    - go to ISSUE.
//  - ISSUE: one cell per cycle, drives oX = cx<<HALVING and oY = cy<<HALVING.
//    - cx++; on cx = GRID-1, cx wraps to 0 and cy++.
//    - Issue k (0..255) is driven in cycle k+1 after E0.
//    - After (GRID-1, GRID-1) is issued, go to DRAIN.
//    - oX/oY hold their last value until the next scan.
//  - Alignment: an LAT-deep valid shift register tags each issue.
//    iVAL is accumulated only when the tag exits the register, so exactly 256 samples are taken.
//  - DRAIN: wait until the shift register is empty (LAT cycles), then go to DONE.
//  - DONE: one cycle.
//    - oDONE = 1, oBUSY = 1.
//    - Accumulators are copied into oDARK_CNT/oSUM on entry; outputs change only here and on reset.
//    - Next state IDLE.
//  - oDONE is high in cycle 256+LAT+1 after E0; with LAT = 3 that is cycle 260.
//  - iSTART in ISSUE, DRAIN or DONE is ignored; it is not queued.
//  - Arithmetic: the 9-bit and 18-bit accumulators cannot overflow for GRID = 16; no saturation is required.
// CONFIGURATION
//  - TMPL_SCAN_BBOX_EN defined:
//    - The ports oMIN_X, oMAX_X, oMIN_Y, oMAX_Y and oBBOX_VALID exist.
//    - The min/max of the dark cells' (cx, cy) is tracked, using the cell index delayed by LAT.
//    - These ports update in DONE.
//    - If there are no dark cells: oBBOX_VALID = 0 and all four bbox fields = 0.
//  - TMPL_SCAN_BBOX_EN undefined: the ports and logic are absent; all other behaviour is identical.
// TESTING (bench uses a behavioural ROM model with LAT = 3)
//  1. ROM returns 255 everywhere, pulse iSTART -> oDONE at cycle 260; oDARK_CNT = 0; oSUM = 65280; oBUSY low at cycle 261.
//  2. ROM returns 0 only at cell (3,4) -> oDARK_CNT = 1, oSUM = 65025; bbox (3,3,4,4), oBBOX_VALID = 1.
//  3. Address check -> issue 0: oX = 0, oY = 0; issue 17: oX = 16, oY = 16; issue 255: oX = 240, oY = 240.
//  4. iSTART held high for the whole scan -> exactly one oDONE, then a new scan starts from IDLE.
//  5. iRST pulsed at cycle 100 -> all outputs 0 immediately and no oDONE; the next iSTART yields full scan results.
//  6. Two scans with different ROM data -> outputs keep scan-1 values until the scan-2 oDONE cycle.

Source files
------------

// File: rtl/tmpl_scan_if.sv
// Interface between the template scan sequencer and its surroundings.
// Carries the start/busy/done handshake, the ROM address/data bus and the
// scan results. The bounding-box result signals exist only when
// TMPL_SCAN_BBOX_EN is defined.
interface tmpl_scan_if;
   logic        iSTART;
   logic        oBUSY;
   logic        oDONE;
   logic [12:0] oX;
   logic [12:0] oY;
   logic [9:0]  iVAL;
   logic [8:0]  oDARK_CNT;
   logic [17:0] oSUM;
`ifdef TMPL_SCAN_BBOX_EN
   logic [3:0]  oMIN_X;
   logic [3:0]  oMAX_X;
   logic [3:0]  oMIN_Y;
   logic [3:0]  oMAX_Y;
   logic        oBBOX_VALID;
`endif

   // Sequencer side
   modport slave (
      input  iSTART,
      input  iVAL,
`ifdef TMPL_SCAN_BBOX_EN
      output oMIN_X,
      output oMAX_X,
      output oMIN_Y,
      output oMAX_Y,
      output oBBOX_VALID,
`endif
      output oBUSY,
      output oDONE,
      output oX,
      output oY,
      output oDARK_CNT,
      output oSUM
   );

   // Controller / ROM side
   modport master (
      output iSTART,
      output iVAL,
`ifdef TMPL_SCAN_BBOX_EN
      input  oMIN_X,
      input  oMAX_X,
      input  oMIN_Y,
      input  oMAX_Y,
      input  oBBOX_VALID,
`endif
      input  oBUSY,
      input  oDONE,
      input  oX,
      input  oY,
      input  oDARK_CNT,
      input  oSUM
   );
endinterface

// File: rtl/tmpl_scan_ctrl.sv
// Template scan sequencer: sweeps all GRID x GRID template cells in raster
// order, drives scaled coordinates into a fixed-latency ROM, aligns the
// returned samples with an LAT-deep valid pipe and accumulates dark-cell
// count and pixel sum. Results are published in the single DONE cycle.
// Optional feature macro: TMPL_SCAN_BBOX_EN adds a dark-cell bounding box.
module tmpl_scan_ctrl #(
   parameter int         HALVING = 4,
   parameter int         GRID    = 16,
   parameter int         LAT     = 3,
   parameter logic [9:0] THRESH  = 10'd128
) (
   input logic       iCLK,
   input logic       iRST,
   tmpl_scan_if.slave bus
);

   localparam int CW = $clog2(GRID);
   localparam logic [LAT-1:0] TOP_MASK = LAT'(1) << (LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;

   stateT          state, nextState;
   logic [CW-1:0]  cx, cy;
   logic [LAT-1:0] vldPipe;
   logic [8:0]     darkAcc, darkNext;
   logic [17:0]    sumAcc, sumNext;

   logic lastCell, tagOut, isDark, pipeDrained, enterDone, startNow;

   assign lastCell    = (cx == CW'(GRID - 1)) && (cy == CW'(GRID - 1));
   assign tagOut      = vldPipe[LAT-1];
   assign isDark      = tagOut && (bus.iVAL < THRESH);
   // Only the exiting stage may still hold a tag: it is consumed this edge.
   assign pipeDrained = (vldPipe & ~TOP_MASK) == '0;
   assign enterDone   = (state == DRAIN) && pipeDrained;
   assign startNow    = (state == IDLE) && bus.iSTART;

   // Coordinates follow the cell counters, so they hold after the last issue.
   assign bus.oX = 13'(cx) << HALVING;
   assign bus.oY = 13'(cy) << HALVING;

   // State register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= IDLE;
      else      state <= nextState;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path leaves nextState unassigned (no latch).
      nextState = state;
      case (state)
         IDLE:  if (bus.iSTART) nextState = ISSUE;
         ISSUE: if (lastCell)   nextState = DRAIN;
         DRAIN: if (pipeDrained) nextState = DONE;
         DONE:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      bus.oBUSY = (state != IDLE);
      bus.oDONE = (state == DONE);
   end

   // Accumulator update including the sample exiting the valid pipe
   always_comb begin
      darkNext = darkAcc + {8'd0, isDark};
      sumNext  = sumAcc + (tagOut ? {8'd0, bus.iVAL} : 18'd0);
   end

   // Cell counters, valid pipe, accumulators and published results
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cx            <= '0;
         cy            <= '0;
         vldPipe       <= '0;
         darkAcc       <= '0;
         sumAcc        <= '0;
         bus.oDARK_CNT <= '0;
         bus.oSUM      <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         vldPipe <= (vldPipe << 1) | LAT'(state == ISSUE);
         if (startNow) begin
            cx      <= '0;
            cy      <= '0;
            vldPipe <= '0;
            darkAcc <= '0;
            sumAcc  <= '0;
         end else begin
            darkAcc <= darkNext;
            sumAcc  <= sumNext;
            if (state == ISSUE && !lastCell) begin
               if (cx == CW'(GRID - 1)) begin
                  cx <= '0;
                  cy <= cy + CW'(1);
               end else begin
                  cx <= cx + CW'(1);
               end
            end
         end
         if (enterDone) begin
            bus.oDARK_CNT <= darkNext;
            bus.oSUM      <= sumNext;
         end
      end
   end

`ifdef TMPL_SCAN_BBOX_EN
   logic [2*CW-1:0] idxPipe [LAT];
   logic [CW-1:0]   minX, maxX, minY, maxY;
   logic [CW-1:0]   minXNext, maxXNext, minYNext, maxYNext;
   logic [CW-1:0]   cxD, cyD;
   logic            firstDark;

   assign cxD       = idxPipe[LAT-1][CW-1:0];
   assign cyD       = idxPipe[LAT-1][2*CW-1:CW];
   assign firstDark = (darkAcc == '0);

   // Cell index delay line, aligned with the valid pipe
   always_ff @(posedge iCLK) begin
      // NOTE: no reset here; contents only matter when qualified by vldPipe, which is reset.
      idxPipe[0] <= {cy, cx};
      for (int i = 1; i < LAT; i++) idxPipe[i] <= idxPipe[i-1];
   end

   // Bounding-box update for the exiting sample
   always_comb begin
      minXNext = minX;
      maxXNext = maxX;
      minYNext = minY;
      maxYNext = maxY;
      if (isDark) begin
         if (firstDark || cxD < minX) minXNext = cxD;
         if (firstDark || cxD > maxX) maxXNext = cxD;
         if (firstDark || cyD < minY) minYNext = cyD;
         if (firstDark || cyD > maxY) maxYNext = cyD;
      end
   end

   // Bounding-box accumulators and published box
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         minX            <= '0;
         maxX            <= '0;
         minY            <= '0;
         maxY            <= '0;
         bus.oMIN_X      <= '0;
         bus.oMAX_X      <= '0;
         bus.oMIN_Y      <= '0;
         bus.oMAX_Y      <= '0;
         bus.oBBOX_VALID <= 1'b0;
      end else begin
         if (startNow) begin
            minX <= '0;
            maxX <= '0;
            minY <= '0;
            maxY <= '0;
         end else begin
            minX <= minXNext;
            maxX <= maxXNext;
            minY <= minYNext;
            maxY <= maxYNext;
         end
         if (enterDone) begin
            bus.oMIN_X      <= minXNext;
            bus.oMAX_X      <= maxXNext;
            bus.oMIN_Y      <= minYNext;
            bus.oMAX_Y      <= maxYNext;
            bus.oBBOX_VALID <= (darkNext != '0);
         end
      end
   end
`endif

endmodule

// File: tb/tb_tmpl_scan_ctrl.sv
// Self-checking bench for tmpl_scan_ctrl with a 3-cycle registered ROM model.
// Table-driven fixed patterns, hand-written multi-cycle sequences and random
// ROM contents checked against a whole-array reference model.
module tb_tmpl_scan_ctrl;

   logic iCLK = 1'b0;
   logic iRST;

   tmpl_scan_if bus ();

   tmpl_scan_ctrl dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   always #5 iCLK = ~iCLK;

   // ROM model: address sampled at an edge, data appears three edges later
   logic [9:0] romMem [256];
   logic [9:0] romP0, romP1;
   always @(posedge iCLK) begin
      romP0    <= romMem[{bus.oY[7:4], bus.oX[7:4]}];
      romP1    <= romP0;
      bus.iVAL <= romP1;
   end

   int nCmp = 0;
   int nErr = 0;

   int expDark, expSum, expMinX, expMaxX, expMinY, expMaxY, expBbV;

   typedef struct {
      int fill;  int dx;    int dy;    int dval;
      int eDark; int eSum;
      int eMinX; int eMaxX; int eMinY; int eMaxY; int eBbV;
   } vecT;
   vecT vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      nCmp++;
      if (act !== want) begin
         nErr++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   task automatic fillRom(input int fill, input int dx, input int dy, input int dval);
      for (int i = 0; i < 256; i++) romMem[i] = 10'(fill);
      if (dx >= 0) romMem[dy*16 + dx] = 10'(dval);
   endtask

   // Reference: statistics straight from the ROM contents
   task automatic computeExpected();
      expDark = 0; expSum = 0; expBbV = 0;
      expMinX = 0; expMaxX = 0; expMinY = 0; expMaxY = 0;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) begin
            expSum += int'(romMem[y*16 + x]);
            if (romMem[y*16 + x] < 10'd128) begin
               if (expDark == 0) begin
                  expMinX = x; expMaxX = x; expMinY = y; expMaxY = y;
               end else begin
                  if (x < expMinX) expMinX = x;
                  if (x > expMaxX) expMaxX = x;
                  if (y < expMinY) expMinY = y;
                  if (y > expMaxY) expMaxY = y;
               end
               expDark++;
            end
         end
      expBbV = (expDark != 0);
   endtask

   task automatic checkResults(input string tag, input int d, input int s, input int mnx,
                               input int mxx, input int mny, input int mxy, input int bv);
      check({tag, "_dark"}, 32'(bus.oDARK_CNT), d);
      check({tag, "_sum"},  32'(bus.oSUM), s);
`ifdef TMPL_SCAN_BBOX_EN
      check({tag, "_minx"}, 32'(bus.oMIN_X), mnx);
      check({tag, "_maxx"}, 32'(bus.oMAX_X), mxx);
      check({tag, "_miny"}, 32'(bus.oMIN_Y), mny);
      check({tag, "_maxy"}, 32'(bus.oMAX_Y), mxy);
      check({tag, "_bbv"},  32'(bus.oBBOX_VALID), bv);
`else
      if (mnx + mxx + mny + mxy + bv < 0) $display("unreachable");
`endif
   endtask

   // Pulse iSTART across one edge (E0); returns at the negedge of cycle 1
   task automatic startScan();
      @(negedge iCLK) bus.iSTART = 1'b1;
      @(negedge iCLK) bus.iSTART = 1'b0;
   endtask

   // Advance negedge by negedge until oDONE, bounded
   task automatic waitDone(input int startCyc, output int cyc);
      cyc = startCyc;
      while (bus.oDONE !== 1'b1 && cyc < 400) begin
         @(negedge iCLK);
         cyc++;
      end
   endtask

   task automatic runModelScan(input string tag);
      int cyc;
      computeExpected();
      startScan();
      waitDone(1, cyc);
      check({tag, "_done_cyc"}, cyc, 260);
      checkResults(tag, expDark, expSum, expMinX, expMaxX, expMinY, expMaxY, expBbV);
      @(negedge iCLK);
      check({tag, "_busy_after"}, 32'(bus.oBUSY), 0);
      check({tag, "_done_after"}, 32'(bus.oDONE), 0);
   endtask

   initial begin
      int cyc;
      int doneCnt;
      int aDark, aSum;

      vecs[0] = '{255, -1, -1, 0,    0, 65280,  0, 0, 0, 0, 0};
      vecs[1] = '{255,  3,  4, 0,    1, 65025,  3, 3, 4, 4, 1};
      vecs[2] = '{127, -1, -1, 0,  256, 32512,  0, 15, 0, 15, 1};
      vecs[3] = '{128, -1, -1, 0,    0, 32768,  0, 0, 0, 0, 0};
      vecs[4] = '{1023, -1, -1, 0,   0, 261888, 0, 0, 0, 0, 0};
      vecs[5] = '{200, 15, 15, 5,    1, 51005,  15, 15, 15, 15, 1};
      vecs[6] = '{0,    7,  9, 1023, 255, 1023, 0, 15, 0, 15, 1};

      bus.iSTART = 1'b0;
      iRST = 1'b1;
      fillRom(255, -1, -1, 0);
      repeat (3) @(negedge iCLK);
      check("rst_busy", 32'(bus.oBUSY), 0);
      check("rst_done", 32'(bus.oDONE), 0);
      check("rst_x", 32'(bus.oX), 0);
      check("rst_y", 32'(bus.oY), 0);
      checkResults("rst", 0, 0, 0, 0, 0, 0, 0);
      iRST = 1'b0;
      @(negedge iCLK);

      // Fixed patterns with hand-derived results
      for (int v = 0; v < 7; v++) begin
         fillRom(vecs[v].fill, vecs[v].dx, vecs[v].dy, vecs[v].dval);
         startScan();
         check($sformatf("vec%0d_busy_c1", v), 32'(bus.oBUSY), 1);
         waitDone(1, cyc);
         check($sformatf("vec%0d_done_cyc", v), cyc, 260);
         check($sformatf("vec%0d_busy_c260", v), 32'(bus.oBUSY), 1);
         checkResults($sformatf("vec%0d", v), vecs[v].eDark, vecs[v].eSum, vecs[v].eMinX,
                      vecs[v].eMaxX, vecs[v].eMinY, vecs[v].eMaxY, vecs[v].eBbV);
         @(negedge iCLK);
         check($sformatf("vec%0d_busy_c261", v), 32'(bus.oBUSY), 0);
      end

      // Address sequence: issue k is driven in cycle k+1
      fillRom(300, 5, 6, 9);
      startScan();
      check("addr0_x", 32'(bus.oX), 0);
      check("addr0_y", 32'(bus.oY), 0);
      repeat (17) @(negedge iCLK);
      check("addr17_x", 32'(bus.oX), 16);
      check("addr17_y", 32'(bus.oY), 16);
      repeat (238) @(negedge iCLK);
      check("addr255_x", 32'(bus.oX), 240);
      check("addr255_y", 32'(bus.oY), 240);
      waitDone(256, cyc);
      check("addr_done_cyc", cyc, 260);
      repeat (5) @(negedge iCLK);
      check("addr_hold_x", 32'(bus.oX), 240);
      check("addr_hold_y", 32'(bus.oY), 240);

      // iSTART held high: one oDONE, then a fresh scan from IDLE
      fillRom(255, -1, -1, 0);
      @(negedge iCLK) bus.iSTART = 1'b1;
      doneCnt = 0;
      for (int c = 1; c <= 261; c++) begin
         @(negedge iCLK);
         if (bus.oDONE === 1'b1) doneCnt++;
         if (c == 261) check("hold_busy_c261", 32'(bus.oBUSY), 0);
      end
      check("hold_done_count", doneCnt, 1);
      @(negedge iCLK);
      check("hold_rescan_busy", 32'(bus.oBUSY), 1);
      check("hold_rescan_x", 32'(bus.oX), 0);
      bus.iSTART = 1'b0;
      waitDone(1, cyc);
      check("hold_rescan_done_cyc", cyc, 260);
      @(negedge iCLK);

      // Reset at cycle 100 aborts the scan
      fillRom(50, -1, -1, 0);
      startScan();
      repeat (99) @(negedge iCLK);
      iRST = 1'b1;
      #1;
      check("abort_busy", 32'(bus.oBUSY), 0);
      check("abort_x", 32'(bus.oX), 0);
      checkResults("abort", 0, 0, 0, 0, 0, 0, 0);
      @(negedge iCLK) iRST = 1'b0;
      doneCnt = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge iCLK);
         if (bus.oDONE === 1'b1) doneCnt++;
      end
      check("abort_no_done", doneCnt, 0);
      runModelScan("post_abort");

      // Two scans: outputs keep scan-1 values until scan-2 oDONE
      fillRom(300, 2, 2, 50);
      runModelScan("two_a");
      aDark = expDark;
      aSum  = expSum;
      for (int i = 0; i < 256; i++) romMem[i] = 10'($urandom_range(0, 1023));
      computeExpected();
      startScan();
      for (int c = 1; c < 260; c++) begin
         if (c == 1 || c == 150 || c == 259) begin
            check($sformatf("two_hold_dark_c%0d", c), 32'(bus.oDARK_CNT), aDark);
            check($sformatf("two_hold_sum_c%0d", c), 32'(bus.oSUM), aSum);
         end
         @(negedge iCLK);
      end
      check("two_b_done", 32'(bus.oDONE), 1);
      checkResults("two_b", expDark, expSum, expMinX, expMaxX, expMinY, expMaxY, expBbV);
      @(negedge iCLK);

      // Random ROM contents: dense and sparse dark-cell mixes
      for (int r = 0; r < 6; r++) begin
         if (r % 2 == 0) begin
            for (int i = 0; i < 256; i++)
               romMem[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 127))
                                                       : 10'($urandom_range(128, 1023));
         end else begin
            for (int i = 0; i < 256; i++) romMem[i] = 10'($urandom_range(128, 1023));
            for (int k = 0; k < 3; k++) romMem[$urandom_range(0, 255)] = 10'($urandom_range(0, 127));
         end
         runModelScan($sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
